// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the decade counter family.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BCD_ZERO   = 4'd0;
    localparam int         MAX_DIGITS = 8;
    localparam int         MAX_WIDTH  = 4 * MAX_DIGITS;

    // Clamp a nibble into the legal decimal range 0..9.
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

    // True when a nibble is not a legal decimal digit.
    function automatic logic bcd_is_bad(input logic [3:0] digit);
        return digit > BCD_MAX;
    endfunction

    // True when every digit of a packed BCD vector (zero-extended to the widest counter) is 0.
    function automatic logic bcd_is_zero(input logic [MAX_WIDTH-1:0] vec);
        return vec == '0;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade digit of the cascaded down-counter: parallel load, decrement on dec_in,
// wrap 0 -> 9 and borrow into the next digit.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_d,
    input  logic       dec_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    // Digit register: load wins over decrement; load_d arrives already clamped to 0..9.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= load_d;
        end else if (dec_in) begin
            digit <= (digit == BCD_ZERO) ? BCD_MAX : (digit - 4'd1);
        end
    end

    // A decrement that lands on a zero digit must be taken from the next digit up.
    assign borrow_out = dec_in & (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded multi-digit BCD down-counter with parallel load, optional auto-reload,
// a one-cycle terminal-count pulse and a sticky bad-digit flag for the last load.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                zero,
    output logic                tc,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]         load_clean;
    logic [DIGITS-1:0]    load_bad;
    logic [W-1:0]         reload_q;
    logic [W-1:0]         digit_d;
    logic                 digit_load;
    logic                 reload_now;
    logic [DIGITS-1:0]    dec_in;
    logic [DIGITS-1:0]    borrow;
    logic                 borrow_unused;
    logic [MAX_WIDTH-1:0] count_ext;

    // Clamp each incoming digit to 9 and note which ones were out of range.
    always_comb begin
        load_clean = '0;
        load_bad   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clean[4*i +: 4] = bcd_sanitize(load_val[4*i +: 4]);
            load_bad[i]          = bcd_is_bad(load_val[4*i +: 4]);
        end
    end

    // Widen the count so the shared zero/one decode works for any digit count.
    always_comb begin
        count_ext        = '0;
        count_ext[W-1:0] = count;
    end

    assign zero = bcd_is_zero(count_ext);

    // Reload only happens on an enabled cycle at zero with no explicit load competing.
    assign reload_now = AUTO_RELOAD & en & ~load & zero;
    assign digit_load = load | reload_now;
    assign digit_d    = load ? load_clean : reload_q;

    // Decrement enters at digit 0 only when there is something left to count.
    assign dec_in[0] = en & ~load & ~zero;

    for (genvar g = 0; g < DIGITS - 1; g++) begin : g_chain
        assign dec_in[g+1] = borrow[g];
    end

    // The top digit never borrows because decrement is gated off at zero.
    assign borrow_unused = borrow[DIGITS-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (digit_load),
            .load_d     (digit_d[4*g +: 4]),
            .dec_in     (dec_in[g]),
            .digit      (count[4*g +: 4]),
            .borrow_out (borrow[g])
        );
    end

    // Reload value, sticky error and terminal-count pulse; tc fires only when a
    // decrement takes the count from 0..01 to 0, so it can never last two cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q <= '0;
            err      <= 1'b0;
            tc       <= 1'b0;
        end else if (load) begin
            reload_q <= load_clean;
            err      <= |load_bad;
            tc       <= 1'b0;
        end else begin
            tc       <= dec_in[0] & (count_ext == MAX_WIDTH'(1));
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: three configurations driven in parallel,
// expectations from a decimal-arithmetic model, checked by independent monitors.
module tb_bcd_down_counter;

    typedef struct {
        int          dut;
        logic [31:0] cnt;
        logic        z;
        logic        t;
        logic        e;
    } exp_t;

    logic        clk = 1'b1;
    logic        rst;
    logic [2:0]  load_v;
    logic [2:0]  en_v;
    logic [31:0] lv_s [3];
    logic [7:0]  cnt_a, cnt_b;
    logic [15:0] cnt_c;
    logic [2:0]  z_v, tc_v, err_v;

    int checks   = 0;
    int failures = 0;

    exp_t sbq  [$];
    exp_t asyq [$];

    int nd [3] = '{2, 2, 4};
    bit ar [3] = '{1'b0, 1'b1, 1'b1};
    int mv [3];
    int mr [3];
    bit mtc [3];
    bit merr [3];

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en_v[0]), .load(load_v[0]), .load_val(lv_s[0][7:0]),
        .count(cnt_a), .zero(z_v[0]), .tc(tc_v[0]), .err(err_v[0]));

    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en_v[1]), .load(load_v[1]), .load_val(lv_s[1][7:0]),
        .count(cnt_b), .zero(z_v[1]), .tc(tc_v[1]), .err(err_v[1]));

    bcd_down_counter #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en_v[2]), .load(load_v[2]), .load_val(lv_s[2][15:0]),
        .count(cnt_c), .zero(z_v[2]), .tc(tc_v[2]), .err(err_v[2]));

    function automatic int pow10(int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] int_to_bcd(int v, int d);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] act_cnt(int k);
        case (k)
            0:       return {24'h0, cnt_a};
            1:       return {24'h0, cnt_b};
            default: return {16'h0, cnt_c};
        endcase
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, k, $time, act, req);
        end
    endtask

    task automatic compare(exp_t e, string tag);
        chk({tag, "_count"}, e.dut, act_cnt(e.dut), e.cnt);
        chk({tag, "_zero"},  e.dut, 32'(z_v[e.dut]),   32'(e.z));
        chk({tag, "_tc"},    e.dut, 32'(tc_v[e.dut]),  32'(e.t));
        chk({tag, "_err"},   e.dut, 32'(err_v[e.dut]), 32'(e.e));
    endtask

    function automatic exp_t snap(int k);
        exp_t e;
        e.dut = k;
        e.cnt = int_to_bcd(mv[k], nd[k]);
        e.z   = (mv[k] == 0);
        e.t   = mtc[k];
        e.e   = merr[k];
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = 0; mr[k] = 0; mtc[k] = 1'b0; merr[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock with the inputs currently applied, queue the
    // expected post-edge state, then move to the next falling edge.
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                mv[k] = 0; mr[k] = 0; mtc[k] = 1'b0; merr[k] = 1'b0;
            end else if (load_v[k]) begin
                int  v   = 0;
                bit  bad = 1'b0;
                for (int i = 0; i < nd[k]; i++) begin
                    int dg = int'(lv_s[k][4*i +: 4]);
                    if (dg > 9) begin bad = 1'b1; dg = 9; end
                    v = v + dg * pow10(i);
                end
                mv[k] = v; mr[k] = v; merr[k] = bad; mtc[k] = 1'b0;
            end else if (en_v[k]) begin
                if (mv[k] != 0) begin
                    mv[k]  = mv[k] - 1;
                    mtc[k] = (mv[k] == 0);
                end else begin
                    mtc[k] = 1'b0;
                    if (ar[k]) mv[k] = mr[k];
                end
            end else begin
                mtc[k] = 1'b0;
            end
            sbq.push_back(snap(k));
        end
        @(negedge clk);
    endtask

    task automatic set_all(logic ld, logic e, logic [31:0] v);
        load_v = {3{ld}};
        en_v   = {3{e}};
        for (int k = 0; k < 3; k++) lv_s[k] = v;
    endtask

    // Synchronous monitor: everything queued for this edge is checked just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0) compare(sbq.pop_front(), "sync");
        end
    end

    // Asynchronous-reset monitor: checked shortly after rst falls, before any edge.
    initial begin
        forever begin
            @(negedge rst);
            #1;
            while (asyq.size() > 0) compare(asyq.pop_front(), "async_rst");
        end
    end

    initial begin
        rst = 1'b0;
        set_all(1'b0, 1'b0, 32'h0);
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // countdown 12 -> 00, then hold at zero (or reload for the auto-reload units)
        set_all(1'b1, 1'b0, 32'h12); tick();
        set_all(1'b0, 1'b1, 32'h0);
        repeat (12) tick();
        repeat (5) tick();

        // short reload cycle
        set_all(1'b1, 1'b0, 32'h03); tick();
        set_all(1'b0, 1'b1, 32'h0);
        repeat (9) tick();

        // clamped load, clean load, load beating enable
        set_all(1'b1, 1'b0, 32'h2F); tick();
        set_all(1'b1, 1'b0, 32'h45); tick();
        set_all(1'b1, 1'b1, 32'h37); tick();
        set_all(1'b0, 1'b0, 32'h0);  tick();

        // full borrow ripple across four digits
        set_all(1'b1, 1'b0, 32'h1000); tick();
        set_all(1'b0, 1'b1, 32'h0);    tick();
        set_all(1'b0, 1'b0, 32'h0);    tick();

        // asynchronous reset mid-count, then enable alone must not restart counting
        set_all(1'b1, 1'b0, 32'h5A); tick();
        set_all(1'b0, 1'b1, 32'h0);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) asyq.push_back(snap(k));
        tick();
        rst = 1'b1;
        repeat (3) tick();
        set_all(1'b1, 1'b0, 32'h07); tick();
        set_all(1'b0, 1'b1, 32'h0);
        repeat (8) tick();

        // randomized traffic, biased toward small values so zero is reached often
        repeat (400) begin
            for (int k = 0; k < 3; k++) begin
                load_v[k] = ($urandom_range(0, 7) == 0);
                en_v[k]   = ($urandom_range(0, 3) != 0);
                lv_s[k]   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 'h25));
            end
            tick();
        end

        set_all(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 0, 32'(sbq.size() + asyq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
